// File: rtl/sha3_pad_packer.sv
// Byte-stream front end for keccak: packs bytes into rate-sized blocks, applies
// SHA-3 pad10*1 (with domain bits) and hands each block to the core.
module sha3_pad_packer #(
   parameter int D = 256,
   parameter int R = 1600 - 2 * D
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   input  logic         in_last,
   input  logic         in_nobyte,
   output logic         in_ready,
   output logic [R-1:0] blk_data,
   output logic         blk_valid,
   output logic         blk_last,
   input  logic         blk_ready,
   output logic [1:0]   dbg_state
);

   localparam int RB = R / 8;
   localparam int IW = $clog2(RB);
   localparam logic [IW-1:0] LAST_IDX = IW'(RB - 1);

   localparam logic [1:0] S_FILL = 2'd0;
   localparam logic [1:0] S_PAD  = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          pend_pad_q, pend_pad_d;
   logic          blk_last_q, blk_last_d;
   logic [R-1:0]  data_q, data_d;

   // Both ports: a beat transfers on a rising edge where valid & ready are high.
   // in_ready depends only on state; blk_data/blk_last hold while blk_valid & !blk_ready.
   assign in_ready  = (state_q == S_FILL);
   assign blk_valid = (state_q == S_OUT);
   assign blk_last  = blk_last_q;
   assign blk_data  = data_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      pend_pad_d = pend_pad_q;
      blk_last_d = blk_last_q;
      data_d     = data_q;
      case (state_q)
         S_FILL: begin
            if (in_valid) begin
               if (in_last && in_nobyte) begin
                  state_d = S_PAD;
               end else begin
                  for (int k = 0; k < RB; k++) begin
                     if (IW'(k) == idx_q) data_d[R-1-8*k -: 8] = in_data;
                  end
                  if (idx_q == LAST_IDX) begin
                     // A message ending exactly on a block boundary still owes a pad block.
                     state_d    = S_OUT;
                     blk_last_d = 1'b0;
                     pend_pad_d = in_last;
                  end else begin
                     idx_d = idx_q + IW'(1);
                     if (in_last) state_d = S_PAD;
                  end
               end
            end
         end
         S_PAD: begin
            // 0x60/0x01 are keccak's bit-reversed forms of the 0x06 domain byte and 0x80 end bit.
            for (int k = 0; k < RB; k++) begin
               if (IW'(k) >= idx_q) begin
                  data_d[R-1-8*k -: 8] = 8'h00;
                  if (IW'(k) == idx_q) data_d[R-1-8*k -: 8] = 8'h60;
                  if (k == RB - 1) data_d[R-1-8*k -: 8] = data_d[R-1-8*k -: 8] | 8'h01;
               end
            end
            state_d    = S_OUT;
            blk_last_d = 1'b1;
            pend_pad_d = 1'b0;
         end
         S_OUT: begin
            if (blk_ready) begin
               idx_d   = '0;
               state_d = pend_pad_q ? S_PAD : S_FILL;
            end
         end
         default: begin
            state_d = S_FILL;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_FILL;
         idx_q      <= '0;
         pend_pad_q <= 1'b0;
         blk_last_q <= 1'b0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         pend_pad_q <= pend_pad_d;
         blk_last_q <= blk_last_d;
         data_q     <= data_d;
      end
   end

endmodule

// File: tb/tb_sha3_pad_packer.sv
// Self-checking bench for sha3_pad_packer: a message-level padding model feeds
// an expected-block queue checked every cycle blk_valid is high.
module tb_sha3_pad_packer;

   localparam int D  = 256;
   localparam int R  = 1600 - 2 * D;
   localparam int RB = R / 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic [7:0]   in_data;
   logic         in_valid, in_last, in_nobyte, in_ready;
   logic [R-1:0] blk_data;
   logic         blk_valid, blk_last, blk_ready;
   logic [1:0]   dbg_state;

   sha3_pad_packer #(.D(D), .R(R)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_nobyte (in_nobyte),
      .in_ready  (in_ready),
      .blk_data  (blk_data),
      .blk_valid (blk_valid),
      .blk_last  (blk_last),
      .blk_ready (blk_ready),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [R-1:0] exp_q[$];
   logic         exp_last_q[$];
   logic [7:0]   msg_q[$];
   int           checks = 0;
   int           failures = 0;
   int           hs_count = 0;
   logic [R-1:0] seen_blk;
   logic         seen_last;
   logic [R-1:0] abc_blk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic chk_blk(input string name, input logic [R-1:0] act, input logic [R-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] byte_of(input logic [R-1:0] b, input int k);
      logic [R-1:0] t;
      t = b >> (R - 8 - 8 * k);
      return t[7:0];
   endfunction

   // Pad the whole message as SHA-3 does, then cut it into RB-byte blocks.
   task automatic push_expected();
      int n, nblk;
      logic [7:0]   padded[$];
      logic [R-1:0] blk;
      n = msg_q.size();
      nblk = n / RB + 1;
      padded = msg_q;
      while (padded.size() < nblk * RB) padded.push_back(8'h00);
      padded[n] = padded[n] | 8'h60;
      padded[nblk*RB-1] = padded[nblk*RB-1] | 8'h01;
      for (int b = 0; b < nblk; b++) begin
         blk = '0;
         for (int k = 0; k < RB; k++) blk = (blk << 8) | R'(padded[b*RB+k]);
         exp_q.push_back(blk);
         exp_last_q.push_back(b == nblk - 1);
      end
   endtask

   always @(negedge clk) begin
      if (reset && blk_valid) begin
         chk("in_ready_low_in_out", in_ready, 1'b0);
         if (exp_q.size() == 0) begin
            chk("unexpected_block", 1'b1, 1'b0);
         end else begin
            chk_blk("blk_data", blk_data, exp_q[0]);
            chk("blk_last", blk_last, exp_last_q[0]);
            if (blk_ready) begin
               seen_blk  = blk_data;
               seen_last = blk_last;
               void'(exp_q.pop_front());
               void'(exp_last_q.pop_front());
               hs_count++;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_beat(input logic [7:0] d, input logic last, input logic nobyte);
      int   t;
      logic rdy;
      in_data   = d;
      in_valid  = 1'b1;
      in_last   = last;
      in_nobyte = nobyte;
      t = 0;
      do begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!rdy && t < 200);
      if (!rdy) chk("accept_timeout", 1'b0, 1'b1);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_nobyte = 1'b0;
   endtask

   task automatic send_msg();
      if (msg_q.size() == 0) send_beat(8'h00, 1'b1, 1'b1);
      for (int i = 0; i < msg_q.size(); i++) send_beat(msg_q[i], i == msg_q.size() - 1, 1'b0);
   endtask

   task automatic wait_hs(input int target);
      int t;
      t = 0;
      while (hs_count < target && t < 1000) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("handshake_reached", hs_count >= target, 1'b1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_nobyte = 1'b0;
      blk_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_blk_valid", blk_valid, 1'b0);
      chk("rst_blk_last", blk_last, 1'b0);
      chk_blk("rst_blk_data", blk_data, '0);
      chk("rst_in_ready", in_ready, 1'b1);
      @(posedge clk); #1 reset = 1'b1;

      // empty message
      msg_q = {};
      push_expected();
      send_beat(8'h00, 1'b1, 1'b1);
      @(negedge clk); chk("empty_pad_cycle_valid", blk_valid, 1'b0);
      @(negedge clk); chk("empty_valid_rise", blk_valid, 1'b1);
      wait_hs(1);
      chk("empty_b0", byte_of(seen_blk, 0), 8'h60);
      chk("empty_b1", byte_of(seen_blk, 1), 8'h00);
      chk("empty_b134", byte_of(seen_blk, 134), 8'h00);
      chk("empty_b135", byte_of(seen_blk, 135), 8'h01);
      chk("empty_last", seen_last, 1'b1);

      // "abc"
      msg_q = {8'h61, 8'h62, 8'h63};
      push_expected();
      send_msg();
      wait_hs(2);
      abc_blk = seen_blk;
      chk("abc_b0", byte_of(seen_blk, 0), 8'h61);
      chk("abc_b2", byte_of(seen_blk, 2), 8'h63);
      chk("abc_b3", byte_of(seen_blk, 3), 8'h60);
      chk("abc_b4", byte_of(seen_blk, 4), 8'h00);
      chk("abc_b135", byte_of(seen_blk, 135), 8'h01);

      // 135 bytes: pad collapses into a single 0x61
      msg_q = {};
      for (int i = 0; i < RB - 1; i++) msg_q.push_back(8'(i));
      push_expected();
      send_msg();
      wait_hs(3);
      chk("b135_b134", byte_of(seen_blk, 134), 8'h86);
      chk("b135_b135", byte_of(seen_blk, 135), 8'h61);
      chk("b135_last", seen_last, 1'b1);

      // 136 bytes: data block then a full pad block
      msg_q = {};
      for (int i = 0; i < RB; i++) msg_q.push_back(8'(i));
      push_expected();
      send_msg();
      @(negedge clk);
      chk("b136_blk1_valid", blk_valid, 1'b1);
      chk("b136_blk1_last", blk_last, 1'b0);
      @(negedge clk);
      chk("b136_pad_valid", blk_valid, 1'b0);
      chk("b136_pad_in_ready", in_ready, 1'b0);
      @(negedge clk);
      chk("b136_blk2_valid", blk_valid, 1'b1);
      chk("b136_blk2_last", blk_last, 1'b1);
      wait_hs(5);
      chk("b136_pad_b0", byte_of(seen_blk, 0), 8'h60);
      chk("b136_pad_b135", byte_of(seen_blk, 135), 8'h01);

      // 300 bytes: two data blocks plus a 28-byte tail
      msg_q = {};
      for (int i = 0; i < 300; i++) msg_q.push_back(8'(i * 7));
      push_expected();
      send_msg();
      wait_hs(8);
      chk("m300_tail_b28", byte_of(seen_blk, 28), 8'h60);

      // backpressure on "abc" with a following byte waiting
      blk_ready = 1'b0;
      msg_q = {8'h61, 8'h62, 8'h63};
      push_expected();
      send_msg();
      @(negedge clk); chk("bp_pad_valid", blk_valid, 1'b0);
      @(posedge clk); #1;
      msg_q = {8'h11};
      push_expected();
      in_data = 8'h11; in_valid = 1'b1; in_last = 1'b1; in_nobyte = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready_held", in_ready, 1'b0);
         chk("bp_valid_held", blk_valid, 1'b1);
      end
      @(posedge clk); #1 blk_ready = 1'b1;
      @(negedge clk); chk("bp_hs_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_accept_in_ready", in_ready, 1'b1);
      chk("bp_accept_valid", blk_valid, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      wait_hs(10);
      chk("bp_next_b0", byte_of(seen_blk, 0), 8'h11);
      chk("bp_next_b1", byte_of(seen_blk, 1), 8'h60);

      // reset mid-FILL after 50 bytes, then "abc"
      for (int i = 0; i < 50; i++) send_beat(8'(8'hA0 + i), 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      chk("rst_fill_in_ready", in_ready, 1'b1);
      chk("rst_fill_valid", blk_valid, 1'b0);
      @(posedge clk); @(posedge clk); #1 reset = 1'b1;
      msg_q = {8'h61, 8'h62, 8'h63};
      push_expected();
      send_msg();
      wait_hs(11);
      chk_blk("rst_fill_abc_same", seen_blk, abc_blk);

      // reset while a block is being presented
      blk_ready = 1'b0;
      msg_q = {8'h71};
      push_expected();
      send_msg();
      @(negedge clk);
      @(negedge clk); chk("rst_out_valid_before", blk_valid, 1'b1);
      reset = 1'b0;
      #1;
      chk("rst_out_valid_drop", blk_valid, 1'b0);
      chk("rst_out_last_drop", blk_last, 1'b0);
      exp_q.delete();
      exp_last_q.delete();
      @(posedge clk); #1 reset = 1'b1; blk_ready = 1'b1;
      msg_q = {8'h61, 8'h62, 8'h63};
      push_expected();
      send_msg();
      wait_hs(12);
      chk_blk("rst_out_abc_same", seen_blk, abc_blk);

      repeat (3) @(posedge clk);
      #1;
      chk("exp_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sha3_pad_packer.md
# sha3_pad_packer

Byte-stream front end for the `keccak` core. Accepts message bytes one per cycle over a valid/ready handshake and packs them into rate-sized blocks. Applies SHA-3 pad10*1 with domain bits after the final byte, then presents each block to the core over a second valid/ready handshake. Replaces software-side chunking and padding, so the core can sit directly behind a byte source (UART, DMA, file loader).

## Interface
- `D`, 256: digest width in bits; must match the attached `keccak` instance.
- `R`, 1600-2*D: rate in bits; `RB = R/8` bytes per block (136 at default).
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  message byte.
- `in_valid`  in  1  `in_data` valid.
- `in_last`  in  1  with `in_valid`: this beat ends the message.
- `in_nobyte`  in  1  with `in_valid & in_last`: beat carries no byte (empty message / empty tail); `in_data` ignored.
- `in_ready`  out  1  byte accepted when `in_valid & in_ready`.
- `blk_data`  out  R  packed block; first byte of block in bits [R-1:R-8], byte k in [R-1-8k -: 8].
- `blk_valid`  out  1  `blk_data` valid.
- `blk_last`  out  1  with `blk_valid`: final (padded) block of the message.
- `blk_ready`  in  1  block consumed when `blk_valid & blk_ready`.

## Operation
- State: FILL, PAD, OUT. Byte index `idx` (0..RB-1). Flag `pend_pad`.
- FILL: `in_ready=1`. On accept of a data byte, write it to byte slot `idx`.
  - Byte is not last and `idx<RB-1`: `idx++`.
  - Byte is not last and `idx==RB-1`: go to OUT, `blk_last=0`.
  - Byte is last and `idx<RB-1`: `idx++`, go to PAD.
  - Byte is last and `idx==RB-1`: go to OUT, `blk_last=0`, set `pend_pad=1`. An exact multiple of RB needs an extra full pad block.
  - `in_nobyte` last beat: nothing written, `idx` unchanged, go to PAD.
- PAD (one cycle): fill slots `idx..RB-1` in a single write.
  - Slot `idx` = 8'h60.
  - Slot RB-1 = 8'h01.
  - If `idx==RB-1`, that slot = 8'h61.
  - All others = 8'h00.
  - Bit-reversed byte convention of `keccak` (0x06 / 0x80).
  - Then go to OUT with `blk_last=1`, clear `pend_pad`.
- OUT: `in_ready=0`, `blk_valid=1`. `blk_data` and `blk_last` are held stable until `blk_ready`.
  - On handshake: `idx=0`, `blk_valid=0`.
  - If `pend_pad`: go to PAD; this emits block {60, 00.., 01}.
  - Otherwise: go to FILL.
- `in_last` and `in_nobyte` are ignored unless `in_valid` is high. Bytes are never dropped or duplicated.
- Slots of a block are fully rewritten before the block is presented. There is no stale data from the previous block.

## Timing
- Reset (asynchronous, on `reset` low):
  - State FILL, `idx=0`, `pend_pad=0`.
  - `blk_valid=0`, `blk_last=0`, `blk_data='0`.
  - `in_ready=1` (combinational from state; sources must not drive `in_valid` during reset).
- Non-last block: final byte accepted at edge t → `blk_valid=1` after edge t.
- Last block: final byte accepted at edge t → PAD during cycle t+1 → `blk_valid=1` after edge t+1.
- `blk_ready` held high: OUT lasts one cycle. FILL resumes next cycle. Sustained throughput is RB bytes per RB+1 cycles.
- Block exactly full on the last byte: data block → PAD (1 cycle) → pad block, back to back when `blk_ready` is high.
- `in_ready` is low throughout PAD and OUT. `blk_ready` is ignored unless in OUT.
- Reset mid-message (any state): partial block and `pend_pad` are discarded, `blk_valid` drops immediately. The next accepted byte goes to slot 0.

## Test plan
- Empty message (single `in_valid`+`in_last`+`in_nobyte` beat, `blk_ready=1`) → one block: byte0=60, bytes1..134=00, byte135=01, `blk_last=1`, `blk_valid` 2 cycles after the beat.
- "abc" (61 62 63, last on 63) → one block: bytes 61 62 63 60, then 00 to byte134, byte135=01, `blk_last=1`.
- 135 bytes 0x00..0x86 → one block: bytes 0..134 = message, byte135=61, `blk_last=1`.
- 136 bytes → block1 = message, `blk_last=0`; block2 = {60, 134×00, 01}, `blk_last=1`; 2 handshakes total, `in_ready=0` in between.
- Backpressure: "abc" with `blk_ready=0` for 5 cycles after `blk_valid` rises → `blk_data`/`blk_last` stable, `in_ready=0`, a pending `in_valid` byte not accepted until 1 cycle after the handshake.
- Reset low mid-FILL after 50 bytes, release, send "abc" → output identical to the "abc" case; no block emitted for the aborted message.
